// File: rtl/axis_pkg.sv
`default_nettype none
// =============================================================================
// axis_pkg : shared state type, byte-lane helper and defaults for the packer
// Rev 1.0
// =============================================================================
package axis_pkg;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_STALL = 2'd1,
      ST_FULL  = 2'd2
   } pack_state_t;

   localparam int         DEF_DATA_W  = 32;
   localparam int         DEF_BLK_W   = 128;
   localparam logic [7:0] DEF_PAD_VAL = 8'h00;

   // Source byte lane that feeds output lane 'lane' of an nbytes-wide word.
   function automatic int swap_lane(input int lane, input int nbytes, input bit swap);
      return swap ? (nbytes - 1 - lane) : lane;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_blk_reg.sv
`default_nettype none
// =============================================================================
// axis_blk_reg : output block register, AXI-Stream master handshake, block count
// Rev 1.0
// =============================================================================
module axis_blk_reg
   import axis_pkg::*;
#(
   parameter int BLK_W = DEF_BLK_W
) (
   input  logic             aclk,
   input  logic             reset,
   input  logic             load,
   input  logic [BLK_W-1:0] load_data,
   input  logic             load_last,
   input  logic             load_user,
   input  logic             m_axis_tready,
   output logic [BLK_W-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   output logic             m_axis_tlast,
   output logic             m_axis_tuser,
   output logic             fire,
   output logic [31:0]      blk_cnt
);

   assign fire = m_axis_tvalid && m_axis_tready;

   // A load may coincide with a handshake; the new block then replaces the old one.
   always_ff @(posedge aclk) begin
      if (reset) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         blk_cnt       <= '0;
      end else begin
         if (load) begin
            m_axis_tdata  <= load_data;
            m_axis_tlast  <= load_last;
            m_axis_tuser  <= load_user;
            m_axis_tvalid <= 1'b1;
         end else if (fire) begin
            m_axis_tvalid <= 1'b0;
         end
         if (fire) begin
            blk_cnt <= blk_cnt + 32'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/axis_blk_packer.sv
`default_nettype none
// =============================================================================
// axis_blk_packer : packs DATA_W stream words into BLK_W blocks, first word in MSB
// Rev 1.0
// =============================================================================
module axis_blk_packer
   import axis_pkg::*;
#(
   parameter int         DATA_W     = DEF_DATA_W,
   parameter int         BLK_W      = DEF_BLK_W,
   parameter bit         SWAP_BYTES = 1'b1,
   parameter logic [7:0] PAD_VAL    = DEF_PAD_VAL
) (
   input  logic              aclk,
   input  logic              reset,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   output logic [BLK_W-1:0]  m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser,
   output logic [31:0]       blk_cnt
);

   localparam int               N        = BLK_W / DATA_W;
   localparam int               NB       = DATA_W / 8;
   localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [BLK_W-1:0] PAD_BLK  = {N{{NB{PAD_VAL}}}};

   pack_state_t       state, state_nxt;
   logic [IDX_W-1:0]  idx;
   logic [BLK_W-1:0]  fill_data, blk_data, load_data;
   logic              fill_last, fill_user;
   logic [DATA_W-1:0] word;
   logic              accept, close, fire, load, load_from_fill;
   logic              load_last, load_user;

   for (genvar b = 0; b < NB; b++) begin : g_lane
      localparam int SRC = swap_lane(b, NB, SWAP_BYTES);
      assign word[8*b +: 8] = s_axis_tdata[8*SRC +: 8];
   end

   // The fill register restarts as all-pad, so untouched slots are already padded at close.
   for (genvar j = 0; j < N; j++) begin : g_slot
      localparam int HI = BLK_W - 1 - j*DATA_W;
      assign blk_data[HI -: DATA_W] = (idx == IDX_W'(j)) ? word : fill_data[HI -: DATA_W];
   end

   assign s_axis_tready = (state != ST_FULL);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign close         = accept && ((idx == LAST_IDX) || s_axis_tlast);

   always_comb begin
      state_nxt      = state;
      load           = 1'b0;
      load_from_fill = 1'b0;
      unique case (state)
         ST_FILL: begin
            if (close) begin
               state_nxt = ST_STALL;
               load      = 1'b1;
            end
         end
         ST_STALL: begin
            if (close && fire) begin
               load = 1'b1;
            end else if (close) begin
               state_nxt = ST_FULL;
            end else if (fire) begin
               state_nxt = ST_FILL;
            end
         end
         ST_FULL: begin
            if (fire) begin
               state_nxt      = ST_STALL;
               load           = 1'b1;
               load_from_fill = 1'b1;
            end
         end
         default: state_nxt = ST_FILL;
      endcase
   end

   assign load_data = load_from_fill ? fill_data : blk_data;
   assign load_last = load_from_fill ? fill_last : s_axis_tlast;
   assign load_user = load_from_fill ? fill_user : (idx != LAST_IDX);

   always_ff @(posedge aclk) begin
      if (reset) begin
         state     <= ST_FILL;
         idx       <= '0;
         fill_data <= PAD_BLK;
         fill_last <= 1'b0;
         fill_user <= 1'b0;
      end else begin
         state <= state_nxt;
         if (close) begin
            idx <= '0;
         end else if (accept) begin
            idx <= idx + IDX_W'(1);
         end
         if (close && !load) begin
            fill_data <= blk_data;
            fill_last <= s_axis_tlast;
            fill_user <= (idx != LAST_IDX);
         end else if (close || load_from_fill) begin
            fill_data <= PAD_BLK;
         end else if (accept) begin
            fill_data <= blk_data;
         end
      end
   end

   axis_blk_reg #(
      .BLK_W (BLK_W)
   ) u_blk_reg (
      .aclk          (aclk),
      .reset         (reset),
      .load          (load),
      .load_data     (load_data),
      .load_last     (load_last),
      .load_user     (load_user),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .fire          (fire),
      .blk_cnt       (blk_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_axis_blk_packer.sv
`default_nettype none
// =============================================================================
// tb_axis_blk_packer : directed stimulus with a queue-based block model
// Rev 1.0
// =============================================================================
module tb_axis_blk_packer;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  s_tdata;
   logic         s_tvalid, s_tready, s_tlast;
   logic [127:0] m_tdata;
   logic         m_tvalid, m_tready, m_tlast, m_tuser;
   logic [31:0]  blk_cnt;

   logic [63:0]  b_s_tdata;
   logic         b_s_tvalid, b_s_tready, b_s_tlast;
   logic [255:0] b_m_tdata;
   logic         b_m_tvalid, b_m_tready, b_m_tlast, b_m_tuser;
   logic [31:0]  b_blk_cnt;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [127:0] d;
      logic         l;
      logic         u;
   } blk_t;

   blk_t        exp_q[$];
   logic [31:0] part_q[$];
   int          hs_cyc[$];
   logic        prev_v, prev_r, prev_l, prev_u;
   logic [127:0] prev_d;

   logic [63:0] bw [4] = '{64'h0011223344556677, 64'h8899AABBCCDDEEFF,
                           64'h0123456789ABCDEF, 64'hFEDCBA9876543210};

   axis_blk_packer #(
      .DATA_W(32), .BLK_W(128), .SWAP_BYTES(1'b1), .PAD_VAL(8'h00)
   ) dut_a (
      .aclk(clk), .reset(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .blk_cnt(blk_cnt)
   );

   axis_blk_packer #(
      .DATA_W(64), .BLK_W(256), .SWAP_BYTES(1'b0), .PAD_VAL(8'h00)
   ) dut_b (
      .aclk(clk), .reset(rst),
      .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
      .s_axis_tlast(b_s_tlast),
      .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
      .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser), .blk_cnt(b_blk_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: collect byte-reversed words, emit a block at 4 words or tlast, zero-padded.
   task automatic model_push(input logic [31:0] w, input logic last);
      blk_t b;
      part_q.push_back({w[7:0], w[15:8], w[23:16], w[31:24]});
      if (part_q.size() == 4 || last) begin
         b.d = '0;
         for (int i = 0; i < 4; i++)
            b.d = {b.d[95:0], (i < part_q.size()) ? part_q[i] : 32'h0};
         b.l = last;
         b.u = (part_q.size() < 4);
         exp_q.push_back(b);
         part_q.delete();
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         part_q.delete();
         exp_q.delete();
         prev_v <= 1'b0;
         prev_r <= 1'b0;
      end else begin
         if (prev_v && !prev_r) begin
            chk("hold_valid", m_tvalid, 1);
            chk("hold_block", {m_tlast, m_tuser, m_tdata}, {prev_l, prev_u, prev_d});
         end
         if (s_tvalid && s_tready) model_push(s_tdata, s_tlast);
         if (m_tvalid && m_tready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_block: got %h expected none", m_tdata);
            end else begin
               chk("blk_data", m_tdata, exp_q[0].d);
               chk("blk_last", m_tlast, exp_q[0].l);
               chk("blk_user", m_tuser, exp_q[0].u);
               void'(exp_q.pop_front());
            end
         end
         prev_v <= m_tvalid;
         prev_r <= m_tready;
         prev_d <= m_tdata;
         prev_l <= m_tlast;
         prev_u <= m_tuser;
      end
   end

   task automatic send(input logic [31:0] w, input logic l);
      bit ok = 1'b0;
      s_tdata  = w;
      s_tvalid = 1'b1;
      s_tlast  = l;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (s_tready) ok = 1'b1;
         @(posedge clk);
      end
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      chk("send_accept", ok, 1);
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !m_tvalid) done = 1'b1;
      end
      chk("drain_done", done, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int c0;
      rst = 1'b1;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
      b_s_tdata = '0; b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_m_tready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_tuser", m_tuser, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_blk_cnt", blk_cnt, 0);
      chk("rst_tready", s_tready, 1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Full block, default parameters
      send(32'h33221100, 1'b0);
      send(32'h77665544, 1'b0);
      send(32'hBBAA9988, 1'b0);
      send(32'hFFEEDDCC, 1'b1);
      @(negedge clk);
      chk("full_latency_valid", m_tvalid, 1);
      chk("full_data", m_tdata, 128'h00112233445566778899AABBCCDDEEFF);
      chk("full_last", m_tlast, 1);
      chk("full_user", m_tuser, 0);
      drain();

      // Partial block padded on tlast
      send(32'h03020100, 1'b0);
      send(32'h07060504, 1'b1);
      @(negedge clk);
      chk("part_valid", m_tvalid, 1);
      chk("part_data", m_tdata, 128'h0001020304050607_0000000000000000);
      chk("part_user", m_tuser, 1);
      chk("part_last", m_tlast, 1);
      drain();
      chk("blk_cnt_two", blk_cnt, 2);

      // Backpressure: three blocks offered with the sink stalled
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send(32'h10000000 + i, 1'b0);
         if (i == 3) begin
            @(negedge clk);
            chk("bp_ready_after4", s_tready, 1);
            @(posedge clk); #1;
         end
      end
      @(negedge clk);
      chk("bp_ready_after8", s_tready, 0);
      fork
         begin
            for (int i = 8; i < 12; i++) send(32'h10000000 + i, i == 11);
         end
      join_none
      repeat (5) @(negedge clk);
      chk("bp_ready_held", s_tready, 0);
      chk("bp_valid_held", m_tvalid, 1);
      chk("bp_cnt_zero", blk_cnt, 0);
      m_tready = 1'b1;
      wait fork;
      drain();
      chk("bp_blk_cnt", blk_cnt, 3);

      // Close and handshake coinciding in STALL: no input bubble, 4-cycle cadence
      hs_cyc.delete();
      c0 = cyc;
      for (int i = 0; i < 12; i++) begin
         m_tready = (i % 4 == 3) && (i > 3);
         send(32'h20000000 + i, i % 4 == 3);
      end
      chk("tp_burst_cycles", cyc - c0, 12);
      m_tready = 1'b1;
      drain();
      chk("tp_hs_count", hs_cyc.size(), 3);
      if (hs_cyc.size() >= 2) chk("tp_hs_spacing", hs_cyc[1] - hs_cyc[0], 4);

      // Reset in the middle of a block discards it
      send(32'hDEADBEEF, 1'b0);
      send(32'hCAFEF00D, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_rst_no_output", m_tvalid, 0);
      end
      @(posedge clk); #1;
      send(32'hA3A2A1A0, 1'b0);
      send(32'hB3B2B1B0, 1'b0);
      send(32'hC3C2C1C0, 1'b0);
      send(32'hD3D2D1D0, 1'b1);
      @(negedge clk);
      chk("mid_rst_valid", m_tvalid, 1);
      chk("mid_rst_data", m_tdata, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
      drain();
      chk("mid_rst_blk_cnt", blk_cnt, 1);

      // Wide instance, no byte swap
      for (int i = 0; i < 4; i++) begin
         b_s_tdata  = bw[i];
         b_s_tvalid = 1'b1;
         b_s_tlast  = (i == 3);
         @(posedge clk); #1;
      end
      b_s_tvalid = 1'b0;
      b_s_tlast  = 1'b0;
      @(negedge clk);
      chk("wide_latency_valid", b_m_tvalid, 1);
      chk("wide_data", b_m_tdata,
          256'h0011223344556677_8899AABBCCDDEEFF_0123456789ABCDEF_FEDCBA9876543210);
      chk("wide_last", b_m_tlast, 1);
      chk("wide_user", b_m_tuser, 0);
      @(negedge clk);
      chk("wide_blk_cnt", b_blk_cnt, 1);

      chk("model_empty", exp_q.size(), 0);
      chk("partial_empty", part_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
